apu_pulse_gen: RTL and testbench
================================

Name: apu_pulse_gen

Overview:
Parametrised successor of the XLS-style APU pulse channel. It adds configurable period width, a volume-scaled multi-bit sample output, a hardware frequency sweep unit and mute rules. Configuration arrives on valid/ready input channels. The sample stream leaves on a valid/ready output channel. It sits behind the Tiny Tapeout top wrapper, which maps channels onto ui/uio/uo pins.

Parameters:
PERIOD_W, 11, timer/period register width
VOL_W, 4, volume and output sample width
MIN_PERIOD, 8, periods below this value mute the output

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
apu__period_r  in  PERIOD_W  new period value
apu__period_r_vld  in  1  period valid
apu__period_r_rdy  out  1  period ready
apu__duty_r  in  2  duty select
apu__duty_r_vld / apu__duty_r_rdy  in/out  1  duty handshake
apu__volume_r  in  VOL_W  sample amplitude
apu__volume_r_vld / apu__volume_r_rdy  in/out  1  volume handshake
apu__sweep_r  in  8  {en[7], div[6:4], negate[3], shift[2:0]}
apu__sweep_r_vld / apu__sweep_r_rdy  in/out  1  sweep handshake
apu__output_s  out  VOL_W  sample
apu__output_s_vld  out  1  sample valid
apu__output_s_rdy  in  1  sample accepted by consumer

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: all config registers, timer, seq_idx (3b) and sweep divider are 0; sweep disabled; apu__output_s=0; all *_rdy=0; output_s_vld=0.
- Out of reset, every *_rdy and output_s_vld is 1 from the first clock edge after reset deasserts.
- Config channels: a register updates on the edge where vld&rdy. It is visible to the sample presented in the following cycle.
  - A period write does not touch the timer. The new period takes effect at the next reload.
  - A duty write does not reset seq_idx.
- Step = the cycle where output_s_vld&output_s_rdy. The timer, sequencer and sweep advance only on steps, so backpressure freezes all state.
- On a step:
  - timer==0 → timer<=period and seq_idx<=seq_idx+1 (mod 8).
  - Otherwise timer<=timer-1.
  - A seq_idx 7→0 transition is a "wrap".
- Duty patterns, high on steps: duty0 {7}; duty1 {6,7}; duty2 {4..7}; duty3 {0..5}.
- Sweep target (PERIOD_W+1 bits): period+(period>>shift), or period-(period>>shift) when negate=1. Subtraction never underflows.
- mute = (period<MIN_PERIOD) | (negate==0 & target[PERIOD_W]). Mute is evaluated continuously, independent of sweep enable.
- apu__output_s = (pattern[duty][seq_idx] & !mute) ? volume : 0. The output is combinational from registers, with zero latency to the current state.
- Sweep on wrap:
  - divider==0 → divider<=div; if en & shift!=0 & !mute, period<=target[PERIOD_W-1:0].
  - Otherwise divider<=divider-1.
- A sweep_r write reloads divider<=div.
- A host period write in the same cycle as a sweep update: the host write wins.
- Reset asserted mid-operation: immediate return to reset values; an in-flight handshake is lost.

Optional Feature:
APU_PULSE_LENGTH_EN
- Defined: adds ports apu__length_r (8b) with apu__length_r_vld and apu__length_r_rdy (rdy=1 out of reset).
  - A write loads the 8-bit length counter.
  - The counter decrements on each wrap while nonzero.
  - length==0 forces output to 0 (ORed into mute; it does not block the sweep).
  - Reset value is 0, so the channel is silent until length is loaded.
- Undefined: no length ports or counter; output is never length-muted.

Test Plan:
- Reset, then period=8, duty=2, volume=15, output_rdy=1 → samples 0..27 are 0 and samples 28..63 are 15. The pattern then repeats with a 72-sample cycle.
- Same config, output_rdy low 5 cycles at sample 30 → output_s holds 15 and state is frozen. Resuming continues the sequence without skips.
- period=5 (below MIN_PERIOD) with duty 3, volume 9 → all samples 0; writing period=8 unmutes on the next cycle.
- period=0x100, sweep {en=1, div=0, negate=0, shift=1} → period becomes 0x180 at the first wrap and 0x240 at the second.
- period=0x600, shift=1, add → target 0x900 overflows; output constantly 0 and period stays 0x600. Setting negate=1 unmutes, and period becomes 0x300 on the next wrap.
- reset pulsed asynchronously mid-sequence → all rdy/vld drop immediately and output_s=0. After release, behaviour matches a fresh start (volume 0 → silent).

Source files
------------

// File: rtl/apu_pulse_gen_if.sv
// Channel bundle for apu_pulse_gen: config inputs and the sample output, all valid/ready.
// APU_PULSE_LENGTH_EN adds the length channel.
interface apu_pulse_gen_if #(
  parameter int PERIOD_W = 11,
  parameter int VOL_W    = 4
);
  logic [PERIOD_W-1:0] apu__period_r;
  logic                apu__period_r_vld;
  logic                apu__period_r_rdy;
  logic [1:0]          apu__duty_r;
  logic                apu__duty_r_vld;
  logic                apu__duty_r_rdy;
  logic [VOL_W-1:0]    apu__volume_r;
  logic                apu__volume_r_vld;
  logic                apu__volume_r_rdy;
  logic [7:0]          apu__sweep_r;
  logic                apu__sweep_r_vld;
  logic                apu__sweep_r_rdy;
  logic [VOL_W-1:0]    apu__output_s;
  logic                apu__output_s_vld;
  logic                apu__output_s_rdy;
`ifdef APU_PULSE_LENGTH_EN
  logic [7:0]          apu__length_r;
  logic                apu__length_r_vld;
  logic                apu__length_r_rdy;

  modport slave (
    input  apu__period_r, apu__period_r_vld, apu__duty_r, apu__duty_r_vld,
           apu__volume_r, apu__volume_r_vld, apu__sweep_r, apu__sweep_r_vld,
           apu__output_s_rdy, apu__length_r, apu__length_r_vld,
    output apu__period_r_rdy, apu__duty_r_rdy, apu__volume_r_rdy, apu__sweep_r_rdy,
           apu__output_s, apu__output_s_vld, apu__length_r_rdy
  );
  modport master (
    output apu__period_r, apu__period_r_vld, apu__duty_r, apu__duty_r_vld,
           apu__volume_r, apu__volume_r_vld, apu__sweep_r, apu__sweep_r_vld,
           apu__output_s_rdy, apu__length_r, apu__length_r_vld,
    input  apu__period_r_rdy, apu__duty_r_rdy, apu__volume_r_rdy, apu__sweep_r_rdy,
           apu__output_s, apu__output_s_vld, apu__length_r_rdy
  );
`else
  modport slave (
    input  apu__period_r, apu__period_r_vld, apu__duty_r, apu__duty_r_vld,
           apu__volume_r, apu__volume_r_vld, apu__sweep_r, apu__sweep_r_vld,
           apu__output_s_rdy,
    output apu__period_r_rdy, apu__duty_r_rdy, apu__volume_r_rdy, apu__sweep_r_rdy,
           apu__output_s, apu__output_s_vld
  );
  modport master (
    output apu__period_r, apu__period_r_vld, apu__duty_r, apu__duty_r_vld,
           apu__volume_r, apu__volume_r_vld, apu__sweep_r, apu__sweep_r_vld,
           apu__output_s_rdy,
    input  apu__period_r_rdy, apu__duty_r_rdy, apu__volume_r_rdy, apu__sweep_r_rdy,
           apu__output_s, apu__output_s_vld
  );
`endif
endinterface

// File: rtl/apu_pulse_gen.sv
// APU pulse channel: period timer, 8-step duty sequencer, volume-scaled sample, sweep unit, mute.
// Optional length counter enabled by defining APU_PULSE_LENGTH_EN.
module apu_pulse_gen #(
  parameter int PERIOD_W   = 11,
  parameter int VOL_W      = 4,
  parameter int MIN_PERIOD = 8
) (
  input logic            clk,
  input logic            reset,
  apu_pulse_gen_if.slave apu
);
  logic                live;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] timer;
  logic [1:0]          duty;
  logic [VOL_W-1:0]    volume;
  logic [7:0]          sweep;
  logic [2:0]          seq_idx;
  logic [2:0]          divider;
  logic [PERIOD_W:0]   target;
  logic                sweep_mute;
  logic                mute;
  logic                step;
  logic                wrap;
  logic                sweep_fire;

  function automatic logic [PERIOD_W:0] sweep_target(input logic [PERIOD_W-1:0] p,
                                                      input logic negate,
                                                      input logic [2:0] shift);
    logic [PERIOD_W:0] ext;
    logic [PERIOD_W:0] delta;
    ext   = {1'b0, p};
    delta = ext >> shift;
    return negate ? (ext - delta) : (ext + delta);
  endfunction

  function automatic logic duty_bit(input logic [1:0] d, input logic [2:0] idx);
    logic [7:0] pat;
    case (d)
      2'd0:    pat = 8'b1000_0000;
      2'd1:    pat = 8'b1100_0000;
      2'd2:    pat = 8'b1111_0000;
      default: pat = 8'b0011_1111;
    endcase
    return pat[idx];
  endfunction

  assign target     = sweep_target(period, sweep[3], sweep[2:0]);
  assign sweep_mute = (period < PERIOD_W'(MIN_PERIOD)) | (~sweep[3] & target[PERIOD_W]);
  assign step       = live & apu.apu__output_s_rdy;
  assign wrap       = step & (timer == '0) & (seq_idx == 3'd7);
  assign sweep_fire = wrap & (divider == 3'd0) & sweep[7] & (sweep[2:0] != 3'd0) & ~sweep_mute;

  assign apu.apu__period_r_rdy = live;
  assign apu.apu__duty_r_rdy   = live;
  assign apu.apu__volume_r_rdy = live;
  assign apu.apu__sweep_r_rdy  = live;
  assign apu.apu__output_s_vld = live;
  assign apu.apu__output_s     = (duty_bit(duty, seq_idx) & ~mute) ? volume : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  // Timer and sequencer advance only when the consumer takes a sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer   <= '0;
      seq_idx <= '0;
    end else if (step) begin
      if (timer == '0) begin
        timer   <= period;
        seq_idx <= seq_idx + 3'd1;
      end else begin
        timer   <= timer - PERIOD_W'(1);
      end
    end
  end

  // Host writes take priority over the sweep unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period  <= '0;
      duty    <= '0;
      volume  <= '0;
      sweep   <= '0;
      divider <= '0;
    end else begin
      if (apu.apu__period_r_vld & live) begin
        period <= apu.apu__period_r;
      end else if (sweep_fire) begin
        period <= target[PERIOD_W-1:0];
      end
      if (apu.apu__duty_r_vld & live) begin
        duty <= apu.apu__duty_r;
      end
      if (apu.apu__volume_r_vld & live) begin
        volume <= apu.apu__volume_r;
      end
      if (apu.apu__sweep_r_vld & live) begin
        sweep   <= apu.apu__sweep_r;
        divider <= apu.apu__sweep_r[6:4];
      end else if (wrap) begin
        divider <= (divider == 3'd0) ? sweep[6:4] : divider - 3'd1;
      end
    end
  end

`ifdef APU_PULSE_LENGTH_EN
  logic [7:0] length;

  assign apu.apu__length_r_rdy = live;
  assign mute = sweep_mute | (length == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      length <= 8'd0;
    end else if (apu.apu__length_r_vld & live) begin
      length <= apu.apu__length_r;
    end else if (wrap && (length != 8'd0)) begin
      length <= length - 8'd1;
    end
  end
`else
  assign mute = sweep_mute;
`endif

endmodule

// File: tb/tb_apu_pulse_gen.sv
// Directed bench for apu_pulse_gen: rule-level reference model compared every cycle,
// plus literal sample expectations for each scenario.
module tb_apu_pulse_gen;
  localparam int PERIOD_W   = 11;
  localparam int VOL_W      = 4;
  localparam int MIN_PERIOD = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apu_pulse_gen_if #(.PERIOD_W(PERIOD_W), .VOL_W(VOL_W)) apu ();

  apu_pulse_gen #(.PERIOD_W(PERIOD_W), .VOL_W(VOL_W), .MIN_PERIOD(MIN_PERIOD)) dut (
    .clk  (clk),
    .reset(reset),
    .apu  (apu)
  );

  // Reference model state
  int m_period, m_duty, m_vol, m_sweep, m_timer, m_seq, m_div, m_len;
  bit m_live;
  int wraps;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int target_of(input int p, input int sw);
    int d;
    d = p >> (sw & 7);
    return ((sw >> 3) & 1) != 0 ? p - d : p + d;
  endfunction

  function automatic bit sweep_muted(input int p, input int sw);
    return (p < MIN_PERIOD) || (((sw >> 3) & 1) == 0 && target_of(p, sw) >= (1 << PERIOD_W));
  endfunction

  function automatic bit duty_high(input int d, input int s);
    case (d)
      0:       return s == 7;
      1:       return s >= 6;
      2:       return s >= 4;
      default: return s <= 5;
    endcase
  endfunction

  function automatic int lit_t1(input int s);
    return ((s % 72) >= 28 && (s % 72) <= 63) ? 15 : 0;
  endfunction

  task automatic model_reset();
    m_period = 0; m_duty = 0; m_vol = 0; m_sweep = 0;
    m_timer = 0; m_seq = 0; m_div = 0; m_len = 0; m_live = 0; wraps = 0;
  endtask

  task automatic model_edge();
    bit stp, wrp;
    int nper, ndiv;
    stp  = m_live && apu.apu__output_s_rdy;
    wrp  = stp && m_timer == 0 && m_seq == 7;
    nper = m_period;
    ndiv = m_div;
    if (wrp) begin
      wraps++;
      if (m_div == 0) begin
        ndiv = (m_sweep >> 4) & 7;
        if (((m_sweep >> 7) & 1) != 0 && (m_sweep & 7) != 0 && !sweep_muted(m_period, m_sweep))
          nper = target_of(m_period, m_sweep) % (1 << PERIOD_W);
      end else begin
        ndiv = m_div - 1;
      end
      if (m_len != 0) m_len--;
    end
    if (stp) begin
      if (m_timer == 0) begin
        m_timer = m_period;
        m_seq   = (m_seq + 1) % 8;
      end else begin
        m_timer--;
      end
    end
    if (m_live) begin
      if (apu.apu__period_r_vld) nper = int'(apu.apu__period_r);
      if (apu.apu__duty_r_vld)   m_duty = int'(apu.apu__duty_r);
      if (apu.apu__volume_r_vld) m_vol = int'(apu.apu__volume_r);
      if (apu.apu__sweep_r_vld) begin
        m_sweep = int'(apu.apu__sweep_r);
        ndiv    = (m_sweep >> 4) & 7;
      end
`ifdef APU_PULSE_LENGTH_EN
      if (apu.apu__length_r_vld) m_len = int'(apu.apu__length_r);
`endif
    end
    m_period = nper;
    m_div    = ndiv;
    m_live   = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_edge();
    end
  end

  // Every-cycle comparison against the model
  initial begin
    int eo;
    bit len_ok;
    forever begin
      @(negedge clk);
`ifdef APU_PULSE_LENGTH_EN
      len_ok = (m_len != 0);
`else
      len_ok = 1'b1;
`endif
      eo = (duty_high(m_duty, m_seq) && !sweep_muted(m_period, m_sweep) && len_ok) ? m_vol : 0;
      check("model_out", int'(apu.apu__output_s), eo);
      check("model_vld_rdy",
            int'({apu.apu__output_s_vld, apu.apu__period_r_rdy, apu.apu__duty_r_rdy,
                  apu.apu__volume_r_rdy, apu.apu__sweep_r_rdy}),
            m_live ? 31 : 0);
    end
  end

  task automatic clear_inputs();
    apu.apu__period_r = '0; apu.apu__period_r_vld = 1'b0;
    apu.apu__duty_r   = '0; apu.apu__duty_r_vld   = 1'b0;
    apu.apu__volume_r = '0; apu.apu__volume_r_vld = 1'b0;
    apu.apu__sweep_r  = '0; apu.apu__sweep_r_vld  = 1'b0;
    apu.apu__output_s_rdy = 1'b0;
`ifdef APU_PULSE_LENGTH_EN
    apu.apu__length_r = '0; apu.apu__length_r_vld = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", int'(apu.apu__period_r_rdy & apu.apu__output_s_vld), 1);
  endtask

  task automatic cfg(input int p, input int d, input int v, input int sw);
    apu.apu__period_r = PERIOD_W'(p); apu.apu__period_r_vld = 1'b1;
    apu.apu__duty_r   = 2'(d);        apu.apu__duty_r_vld   = 1'b1;
    apu.apu__volume_r = VOL_W'(v);    apu.apu__volume_r_vld = 1'b1;
    apu.apu__sweep_r  = 8'(sw);       apu.apu__sweep_r_vld  = 1'b1;
`ifdef APU_PULSE_LENGTH_EN
    apu.apu__length_r = 8'd255;       apu.apu__length_r_vld = 1'b1;
`endif
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic wait_wraps(input int n);
    int cnt;
    cnt = 0;
    while (wraps < n && cnt < 30000) begin
      @(negedge clk);
      cnt++;
    end
    check("wrap_wait", int'(wraps >= n), 1);
  endtask

  initial begin
    clear_inputs();
    #2;
    check("reset_out", int'(apu.apu__output_s), 0);
    check("reset_vld", int'(apu.apu__output_s_vld), 0);
    check("reset_rdy", int'(apu.apu__period_r_rdy | apu.apu__sweep_r_rdy), 0);

    // Basic duty-2 waveform, two full 72-sample cycles
    do_reset();
    cfg(8, 2, 15, 0);
    apu.apu__output_s_rdy = 1'b1;
    for (int s = 0; s < 144; s++) begin
      check("t1_sample", int'(apu.apu__output_s), lit_t1(s));
      @(negedge clk);
    end

    // Backpressure at sample 30
    do_reset();
    cfg(8, 2, 15, 0);
    apu.apu__output_s_rdy = 1'b1;
    for (int s = 0; s < 30; s++) begin
      check("t2_sample", int'(apu.apu__output_s), lit_t1(s));
      @(negedge clk);
    end
    check("t2_sample30", int'(apu.apu__output_s), 15);
    apu.apu__output_s_rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t2_hold", int'(apu.apu__output_s), 15);
    end
    apu.apu__output_s_rdy = 1'b1;
    for (int s = 31; s < 72; s++) begin
      @(negedge clk);
      check("t2_resume", int'(apu.apu__output_s), lit_t1(s));
    end

    // Short period mutes; period 8 unmutes on the next cycle
    do_reset();
    cfg(5, 3, 9, 0);
    apu.apu__output_s_rdy = 1'b1;
    for (int s = 0; s <= 20; s++) begin
      check("t3_muted", int'(apu.apu__output_s), 0);
      if (s < 20) @(negedge clk);
    end
    apu.apu__period_r = PERIOD_W'(8);
    apu.apu__period_r_vld = 1'b1;
    @(negedge clk);
    apu.apu__period_r_vld = 1'b0;
    check("t3_unmute", int'(apu.apu__output_s), 9);

    // Upward sweep 0x100 -> 0x180 -> 0x240
    do_reset();
    cfg('h100, 2, 15, 'h81);
    apu.apu__output_s_rdy = 1'b1;
    wait_wraps(1);
    check("t4_period1", m_period, 'h180);
    wait_wraps(2);
    check("t4_period2", m_period, 'h240);

    // Overflowing target mutes and blocks sweep; negate unmutes
    do_reset();
    cfg('h600, 2, 15, 'h81);
    apu.apu__output_s_rdy = 1'b1;
    begin
      int cnt;
      cnt = 0;
      while (wraps < 1 && cnt < 30000) begin
        check("t5_muted", int'(apu.apu__output_s), 0);
        @(negedge clk);
        cnt++;
      end
    end
    check("t5_wrap_seen", int'(wraps >= 1), 1);
    check("t5_period_kept", m_period, 'h600);
    apu.apu__sweep_r = 8'h89;
    apu.apu__sweep_r_vld = 1'b1;
    @(negedge clk);
    apu.apu__sweep_r_vld = 1'b0;
    wait_wraps(2);
    check("t5_period_neg", m_period, 'h300);

    // Asynchronous reset mid-sequence
    do_reset();
    cfg(8, 2, 15, 0);
    apu.apu__output_s_rdy = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_before", int'(apu.apu__output_s), 15);
    #2 reset = 1'b1;
    #1;
    check("t6_async_out", int'(apu.apu__output_s), 0);
    check("t6_async_vld", int'(apu.apu__output_s_vld), 0);
    check("t6_async_rdy", int'(apu.apu__period_r_rdy | apu.apu__volume_r_rdy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_rdy_back", int'(apu.apu__output_s_vld & apu.apu__duty_r_rdy), 1);
    for (int s = 0; s < 80; s++) begin
      check("t6_silent", int'(apu.apu__output_s), 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
